debug_overlay_writer: RTL
=========================

# debug_overlay_writer

Parametrised successor to the single-cycle CPU's debug text writer. It renders the register file plus NUM_CH generic watch channels as hex glyphs into the character background memory (BAM) through a valid/ready write port. Frames are triggered on request with a snapshot of the channels, and rows whose value is unchanged since the last frame are skipped. It sits between the CPU debug taps and the BAM write port of the VGA text path.

## Interface
- CHAR_WIDTH, 8: glyph width in pixels
- CHAR_HEIGHT, 8: glyph height in pixels
- SCREEN_WIDTH, 640; SCREEN_HEIGHT, 480: screen size in pixels
- CHARS_PER_ROW, SCREEN_WIDTH/CHAR_WIDTH; CHARS_PER_COL, SCREEN_HEIGHT/CHAR_HEIGHT: derived text grid
- DATA_W, 32: value width; must be a multiple of 4; DIGITS = DATA_W/4
- NUM_REGS, 32: register rows; REG_AW = clog2(NUM_REGS)
- NUM_CH, 8: watch-channel rows
- ROW_BASE, 0; COL_BASE, 13: screen position of the first digit of row 0
- ADDR_W, 13: BAM address width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- refresh  in  1  one-cycle frame request
- freeze  in  1  while high, refresh is ignored and no frame starts
- force_all  in  1  sampled at SNAP: write every row regardless of change
- ch_data  in  NUM_CH*DATA_W  watch channels; channel k is bits [k*DATA_W +: DATA_W]
- reg_addr  out  REG_AW  register-file read address
- reg_data  in  DATA_W  register read data, valid one cycle after reg_addr
- bam_valid  out  1  write request
- bam_ready  in  1  BAM accepts the write when bam_valid && bam_ready
- bam_addr  out  ADDR_W  character address
- bam_write_data  out  8  glyph code
- busy  out  1  high from SNAP until DONE inclusive
- frame_done  out  1  one-cycle pulse at the end of each frame

## Operation
- Row index r runs 0..NUM_REGS+NUM_CH-1.
  - r < NUM_REGS: register r, on screen row ROW_BASE+r.
  - Otherwise: channel r-NUM_REGS, on screen row ROW_BASE+r+1. The gap row is never written.
- Glyph mapping per nibble d: 0..9 gives 8'h10+d; A..F gives 8'h21+(d-10).
- Digit i (0 = MS nibble) is written at address (screen_row)*CHARS_PER_ROW + COL_BASE + i, truncated to ADDR_W.
- A shadow copy (NUM_REGS+NUM_CH words) holds the last value written per row. A valid flag is cleared by reset, which makes the first frame after reset a full frame.
- FSM:
  - IDLE: on (refresh || pending) && !freeze, go to SNAP.
  - SNAP: latch ch_data into the snapshot; latch force = force_all || !valid; clear pending; set r=0; go to FETCH.
  - FETCH: drive reg_addr=r for register rows (0 for channel rows); go to CMP.
  - CMP: select the row value (reg_data or snapshot word).
    - Unchanged and !force: advance r.
    - Otherwise: load the word register, update the shadow, set digit=0, go to EMIT.
  - EMIT: assert bam_valid. On each handshake, advance digit. After digit DIGITS-1, advance r.
  - Advance r: if last row, go to DONE; else go to FETCH.
  - DONE: pulse frame_done; set valid=1; go to IDLE.
- A refresh arriving while busy sets pending; multiple refreshes collapse into one pending frame.
- A refresh coinciding with DONE also sets pending.
- freeze does not abort a frame already in progress.
- Channel changes after SNAP do not affect the current frame.

## Timing
- Reset values: bam_valid=0, bam_addr=0, bam_write_data=0, reg_addr=0, busy=0, frame_done=0. State is IDLE, pending=0, valid=0.
- Reset is asynchronous: asserting it mid-frame drops bam_valid in the same cycle with no partial-write guarantee.
- While bam_valid && !bam_ready, bam_addr and bam_write_data hold stable and bam_valid stays high.
- Cycles per row:
  - Unchanged row: 2 (FETCH, CMP).
  - Written row: 2 + DIGITS with bam_ready tied high.
- Total frame time is 2 cycles (SNAP, DONE) plus the sum of the row costs.
- From refresh to first bam_valid: 3 cycles (SNAP, FETCH, CMP).

## Structure
- Package debug_overlay_pkg holds:
  - the FSM state enum;
  - the glyph constants GLYPH_DIGIT0=8'h10 and GLYPH_ALPHA_A=8'h21;
  - the function nibble_to_glyph.
- Sub-module debug_hex_glyph (combinational nibble to glyph) is instantiated once on the selected digit.
- Elaboration-time checks:
  - ROW_BASE+NUM_REGS+1+NUM_CH <= CHARS_PER_COL;
  - COL_BASE+DIGITS <= CHARS_PER_ROW;
  - DATA_W%4==0.

## Test plan
- Reset, reg1=32'h0000_00AB, all else 0, refresh, ready=1:
  - full frame of (32+8)*8 writes;
  - addresses 93..100 carry 10,10,10,10,10,10,21,22;
  - frame_done once.
- Second refresh with only reg5 changed to 32'hFFFF_0000:
  - exactly 8 writes at 413..420, glyphs 26,26,26,26,10,10,10,10;
  - frame length 2+40*2+8.
- bam_ready low for 5 cycles mid-row: bam_valid held, addr/data stable, no glyph lost or duplicated.
- Refresh pulsed 3 times while busy: exactly one extra frame follows, starting the cycle after DONE.
- freeze=1 with refresh: busy stays 0. Then freeze=0 with force_all=1 and refresh: all 320 writes issue despite unchanged data.
- rst_n asserted during EMIT: bam_valid low in the same cycle. After release, the next refresh produces a full frame.

Source files
------------

// File: rtl/debug_overlay_pkg.sv
// Shared types, glyph constants and nibble-to-glyph mapping for the debug overlay writer.
// Latency: n/a (package). Backpressure: n/a.
// Contents: writer FSM state enum, glyph code bases, nibble_to_glyph helper.
package debug_overlay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_FETCH,
    ST_CMP,
    ST_EMIT,
    ST_DONE
  } state_t;

  localparam logic [7:0] GLYPH_DIGIT0  = 8'h10;
  localparam logic [7:0] GLYPH_ALPHA_A = 8'h21;

  // The character ROM keeps '0'..'9' and 'A'..'F' in two separate runs.
  function automatic logic [7:0] nibble_to_glyph(input logic [3:0] d);
    if (d < 4'd10) return GLYPH_DIGIT0 + {4'h0, d};
    else           return GLYPH_ALPHA_A + {4'h0, d - 4'd10};
  endfunction

endpackage

// File: rtl/debug_hex_glyph.sv
// Converts one hex nibble to its character-ROM glyph code.
// Latency: combinational. Backpressure: none.
// Ports: nibble (4b in), glyph (8b out).
module debug_hex_glyph
  import debug_overlay_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] glyph
);

  assign glyph = nibble_to_glyph(nibble);

endmodule

// File: rtl/debug_overlay_writer.sv
// Renders register file + NUM_CH snapshot channels as hex text into the BAM, skipping unchanged rows.
// Latency: refresh -> first bam_valid 3 cycles; unchanged row 2 cycles, written row 2+DIGITS cycles.
// Backpressure: bam_valid/bam_ready; addr/data held while stalled, refreshes while busy collapse to one pending frame.
// Ports: clk, rst_n, refresh/freeze/force_all controls, ch_data watch bus, reg_addr/reg_data regfile read
//        port (1-cycle read latency), bam_valid/bam_ready/bam_addr/bam_write_data write port, busy, frame_done.
module debug_overlay_writer
  import debug_overlay_pkg::*;
#(
  parameter int CHAR_WIDTH    = 8,
  parameter int CHAR_HEIGHT   = 8,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int CHARS_PER_ROW = SCREEN_WIDTH / CHAR_WIDTH,
  parameter int CHARS_PER_COL = SCREEN_HEIGHT / CHAR_HEIGHT,
  parameter int DATA_W        = 32,
  parameter int NUM_REGS      = 32,
  parameter int NUM_CH        = 8,
  parameter int ROW_BASE      = 0,
  parameter int COL_BASE      = 13,
  parameter int ADDR_W        = 13,
  localparam int DIGITS       = DATA_W / 4,
  localparam int REG_AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     refresh,
  input  logic                     freeze,
  input  logic                     force_all,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [REG_AW-1:0]        reg_addr,
  input  logic [DATA_W-1:0]        reg_data,
  output logic                     bam_valid,
  input  logic                     bam_ready,
  output logic [ADDR_W-1:0]        bam_addr,
  output logic [7:0]               bam_write_data,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int NUM_ROWS = NUM_REGS + NUM_CH;
  localparam int RW       = $clog2(NUM_ROWS);
  localparam int DGW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [RW-1:0]  LAST_ROW   = RW'(NUM_ROWS - 1);
  localparam logic [DGW-1:0] LAST_DIGIT = DGW'(DIGITS - 1);

  if (ROW_BASE + NUM_REGS + 1 + NUM_CH > CHARS_PER_COL) begin : g_bad_rows
    $error("debug_overlay_writer: rows do not fit on screen");
  end
  if (COL_BASE + DIGITS > CHARS_PER_ROW) begin : g_bad_cols
    $error("debug_overlay_writer: digits do not fit on a row");
  end
  if (DATA_W % 4 != 0) begin : g_bad_width
    $error("debug_overlay_writer: DATA_W must be a multiple of 4");
  end

  state_t                   state;
  logic                     pending;
  logic                     valid;      // shadow holds a complete frame
  logic                     force_q;
  logic [RW-1:0]            row;
  logic [DGW-1:0]           digit;
  logic [DATA_W-1:0]        word;       // row value, shifted left one nibble per accepted glyph
  logic [NUM_CH*DATA_W-1:0] snap;
  logic [DATA_W-1:0]        shadow [NUM_ROWS];

  logic                     is_ch_row;
  logic [DATA_W-1:0]        row_val;
  logic [DATA_W-1:0]        word_nxt;
  int                       screen_row;
  logic [ADDR_W-1:0]        row_addr;
  logic [3:0]               sel_nibble;
  logic [7:0]               sel_glyph;
  logic                     row_changed;
  logic                     take;
  logic                     row_done;
  logic                     last_row;
  logic [RW-1:0]            row_inc;

  always_comb begin
    is_ch_row = (int'(row) >= NUM_REGS);
    row_val   = reg_data;
    if (is_ch_row) row_val = snap[(int'(row) - NUM_REGS)*DATA_W +: DATA_W];
    // Channel rows sit one screen row lower, leaving a blank separator row.
    screen_row = ROW_BASE + int'(row) + (is_ch_row ? 1 : 0);
    row_addr   = ADDR_W'(screen_row * CHARS_PER_ROW + COL_BASE);
    word_nxt   = word << 4;
    // In CMP the glyph of digit 0 is needed; in EMIT the glyph of the digit after the one on the bus.
    sel_nibble  = (state == ST_EMIT) ? word_nxt[DATA_W-1 -: 4] : row_val[DATA_W-1 -: 4];
    row_changed = force_q || (row_val != shadow[row]);
    take        = bam_valid && bam_ready;
    row_done    = ((state == ST_CMP) && !row_changed) ||
                  ((state == ST_EMIT) && take && (digit == LAST_DIGIT));
    last_row    = (row == LAST_ROW);
    row_inc     = row + 1'b1;
  end

  debug_hex_glyph u_glyph (
    .nibble (sel_nibble),
    .glyph  (sel_glyph)
  );

  // Snapshot and shadow carry no reset; the valid flag guards the shadow.
  always_ff @(posedge clk) begin
    if (state == ST_SNAP) snap <= ch_data;
    if ((state == ST_CMP) && row_changed) shadow[row] <= row_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pending        <= 1'b0;
      valid          <= 1'b0;
      force_q        <= 1'b0;
      row            <= '0;
      digit          <= '0;
      word           <= '0;
      reg_addr       <= '0;
      bam_valid      <= 1'b0;
      bam_addr       <= '0;
      bam_write_data <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (refresh && (state != ST_IDLE)) pending <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if ((refresh || pending) && !freeze) begin
            state <= ST_SNAP;
            busy  <= 1'b1;
          end
        end
        ST_SNAP: begin
          force_q  <= force_all || !valid;
          pending  <= refresh;
          row      <= '0;
          reg_addr <= '0;
          state    <= ST_FETCH;
        end
        ST_FETCH: state <= ST_CMP;
        ST_CMP: begin
          if (row_changed) begin
            word           <= row_val;
            digit          <= '0;
            bam_valid      <= 1'b1;
            bam_addr       <= row_addr;
            bam_write_data <= sel_glyph;
            state          <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (take) begin
            if (digit == LAST_DIGIT) begin
              bam_valid <= 1'b0;
            end else begin
              digit          <= digit + 1'b1;
              word           <= word_nxt;
              bam_addr       <= bam_addr + 1'b1;
              bam_write_data <= sel_glyph;
            end
          end
        end
        ST_DONE: begin
          valid <= 1'b1;
          // A queued request chains straight into the next frame.
          if ((pending || refresh) && !freeze) begin
            state <= ST_SNAP;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (row_done) begin
        if (last_row) begin
          state      <= ST_DONE;
          frame_done <= 1'b1;
        end else begin
          row      <= row_inc;
          reg_addr <= (int'(row_inc) < NUM_REGS) ? REG_AW'(row_inc) : '0;
          state    <= ST_FETCH;
        end
      end
    end
  end

endmodule
